// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - two-way set-associative read-allocate write-through data cache
// Optional hit/miss counters enabled by defining CACHE_STATS_EN.
module cache_controller #(
    parameter int          SETS      = 64,
    parameter int          TAG_W     = 10,
    parameter logic [31:0] BASE_ADDR = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        sram_r_en,
    output logic        sram_w_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int IDX_W = $clog2(SETS);
    localparam int AW    = 3 + IDX_W + TAG_W;

    typedef enum logic [1:0] {IDLE, READ_MISS, WRITE} state_t;

    state_t            state;
    logic [SETS-1:0]   valid0, valid1, lru;
    logic [TAG_W-1:0]  tag0 [SETS];
    logic [TAG_W-1:0]  tag1 [SETS];
    logic [63:0]       data0 [SETS];
    logic [63:0]       data1 [SETS];

    // Only bits [AW-1:2] of address-BASE_ADDR matter; the byte offsets feed just the borrow.
    logic              borrow;
    logic [AW-3:0]     mem_word;
    logic              word_sel;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;

    assign borrow   = address[1:0] < BASE_ADDR[1:0];
    assign mem_word = address[AW-1:2] - BASE_ADDR[AW-1:2] - {{(AW-3){1'b0}}, borrow};
    assign word_sel = mem_word[0];
    assign idx      = mem_word[1 +: IDX_W];
    assign tag      = mem_word[1 + IDX_W +: TAG_W];

    logic        hit0, hit1, hit, hit_way, victim;
    logic        load_hit, fill, store_hit;
    logic [63:0] hit_line;

    assign hit0     = valid0[idx] && (tag0[idx] == tag);
    assign hit1     = valid1[idx] && (tag1[idx] == tag);
    assign hit      = hit0 || hit1;
    assign hit_way  = !hit0;
    assign hit_line = hit0 ? data0[idx] : data1[idx];
    assign victim   = !valid0[idx] ? 1'b0 : (!valid1[idx] ? 1'b1 : lru[idx]);

    assign load_hit  = (state == IDLE) && mem_r_en && !mem_w_en && hit;
    assign fill      = (state == READ_MISS) && sram_ready;
    assign store_hit = (state == WRITE) && sram_ready && hit;

    assign sram_r_en    = (state == READ_MISS);
    assign sram_w_en    = (state == WRITE);
    assign sram_address = address;
    assign sram_wdata   = wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            valid0 <= '0;
            valid1 <= '0;
            lru    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_w_en) begin
                        state <= WRITE;
                    end else if (mem_r_en) begin
                        if (hit) lru[idx] <= ~hit_way;
                        else     state    <= READ_MISS;
                    end
                end
                READ_MISS: begin
                    if (sram_ready) begin
                        if (victim) valid1[idx] <= 1'b1;
                        else        valid0[idx] <= 1'b1;
                        lru[idx] <= ~victim;
                        state    <= IDLE;
                    end
                end
                WRITE: begin
                    if (sram_ready) begin
                        if (hit) lru[idx] <= ~hit_way;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag/data storage has no reset: a line is only visible through its valid bit.
    always_ff @(posedge clk) begin
        if (fill) begin
            if (victim) begin
                tag1[idx]  <= tag;
                data1[idx] <= sram_rdata;
            end else begin
                tag0[idx]  <= tag;
                data0[idx] <= sram_rdata;
            end
        end
        if (store_hit) begin
            if (hit0) begin
                if (word_sel) data0[idx][63:32] <= wdata;
                else          data0[idx][31:0]  <= wdata;
            end else begin
                if (word_sel) data1[idx][63:32] <= wdata;
                else          data1[idx][31:0]  <= wdata;
            end
        end
    end

    always_comb begin
        ready = 1'b0;
        rdata = '0;
        case (state)
            IDLE: begin
                ready = !(mem_w_en || (mem_r_en && !hit));
                if (load_hit) rdata = word_sel ? hit_line[63:32] : hit_line[31:0];
            end
            READ_MISS: begin
                ready = sram_ready;
                if (sram_ready) rdata = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];
            end
            WRITE:   ready = sram_ready;
            default: ready = 1'b0;
        endcase
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hits, misses;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hits   <= '0;
            misses <= '0;
        end else begin
            if (load_hit) hits   <= hits + 32'd1;
            if (fill)     misses <= misses + 32'd1;
        end
    end

    assign hit_count  = hits;
    assign miss_count = misses;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - scoreboard bench for cache_controller
module tb_cache_controller;
    logic        clk = 1'b0;
    logic        rst, mem_r_en, mem_w_en, ready, sram_r_en, sram_w_en, sram_ready;
    logic [31:0] address, wdata, rdata, sram_address, sram_wdata, hit_count, miss_count;
    logic [63:0] sram_rdata;

    always #5 clk = ~clk;

    cache_controller dut (
        .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
        .sram_r_en(sram_r_en), .sram_w_en(sram_w_en), .sram_address(sram_address),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    typedef struct {
        string       name;
        logic [31:0] data;
        int          cyc;
        int          rcyc;
        int          wcyc;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          lat = 5;
    logic [63:0] mem [int];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    function automatic int line_key(input logic [31:0] a);
        return int'((a - 32'd1024) >> 3);
    endfunction

    function automatic logic [63:0] line_at(input logic [31:0] a);
        int k;
        k = line_key(a);
        if (mem.exists(k)) return mem[k];
        return {32'hB000_0000 | 32'(k), 32'hA000_0000 | 32'(k)};
    endfunction

    // SRAM controller model: ready while idle, ready again lat cycles into a transaction
    initial begin : responder
        int          cnt;
        logic [63:0] l;
        cnt = 0;
        sram_ready = 1'b1;
        sram_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (sram_r_en || sram_w_en) begin
                cnt++;
                sram_ready = (cnt == lat);
                if (cnt == lat) begin
                    if (sram_r_en) begin
                        sram_rdata = line_at(sram_address);
                    end else begin
                        l = line_at(sram_address);
                        if (sram_address[2]) l[63:32] = sram_wdata;
                        else                 l[31:0]  = sram_wdata;
                        mem[line_key(sram_address)] = l;
                    end
                end
            end else begin
                cnt = 0;
                sram_ready = 1'b1;
            end
        end
    end

    initial begin : monitor
        int   cyc, rcyc, wcyc;
        exp_t e;
        cyc = 0; rcyc = 0; wcyc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cyc = 0; rcyc = 0; wcyc = 0;
            end else if (mem_r_en || mem_w_en) begin
                cyc++;
                rcyc += int'(sram_r_en);
                wcyc += int'(sram_w_en);
                if (ready) begin
                    if (sb.size() == 0) begin
                        check("scoreboard_depth", 32'(sb.size()), 32'd1);
                    end else begin
                        e = sb.pop_front();
                        check({e.name, "/rdata"}, rdata, e.data);
                        check({e.name, "/cycles"}, 32'(cyc), 32'(e.cyc));
                        check({e.name, "/sram_r_cycles"}, 32'(rcyc), 32'(e.rcyc));
                        check({e.name, "/sram_w_cycles"}, 32'(wcyc), 32'(e.wcyc));
                    end
                    cyc = 0; rcyc = 0; wcyc = 0;
                end
            end
        end
    end

    task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_data, input bit miss, input string name);
        exp_t e;
        int   n;
        e.name = name;
        e.data = w ? 32'd0 : exp_data;
        e.cyc  = (w || miss) ? lat + 1 : 1;
        e.rcyc = (!w && miss) ? lat : 0;
        e.wcyc = w ? lat : 0;
        sb.push_back(e);
        mem_w_en = w;
        mem_r_en = !w;
        address  = a;
        wdata    = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!ready && n > 40) begin
                $display("FAIL %s/timeout: ready got 0 expected 1", name);
                vectors++;
                miscompares++;
                finish_run();
            end
        end while (!ready);
        @(posedge clk);
        #1;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; address = '0; wdata = '0;
        mem[0] = 64'h22222222_11111111;
        repeat (2) @(posedge clk);
        #1;
        check("reset/ready", 32'(ready), 32'd1);
        check("reset/sram_r_en", 32'(sram_r_en), 32'd0);
        check("reset/sram_w_en", 32'(sram_w_en), 32'd0);
        check("reset/rdata", rdata, 32'd0);
        check("reset/hit_count", hit_count, 32'd0);
        check("reset/miss_count", miss_count, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        req(1'b0, 32'd1024, 32'd0, 32'h11111111, 1'b1, "ld1024_cold");
        req(1'b0, 32'd1028, 32'd0, 32'h22222222, 1'b0, "ld1028_hit");
        req(1'b0, 32'd1536, 32'd0, 32'hA0000040, 1'b1, "ld1536_way1");
        req(1'b0, 32'd2048, 32'd0, 32'hA0000080, 1'b1, "ld2048_evict0");
        req(1'b0, 32'd1536, 32'd0, 32'hA0000040, 1'b0, "ld1536_kept");
        req(1'b0, 32'd1024, 32'd0, 32'h11111111, 1'b1, "ld1024_reload");
        req(1'b0, 32'd1536, 32'd0, 32'hA0000040, 1'b0, "ld1536_still");
        req(1'b1, 32'd1028, 32'hDEADBEEF, 32'd0, 1'b0, "st1028_hit");
        req(1'b0, 32'd1028, 32'd0, 32'hDEADBEEF, 1'b0, "ld1028_updated");
        req(1'b1, 32'd2048, 32'h12345678, 32'd0, 1'b0, "st2048_noalloc");
        req(1'b0, 32'd2048, 32'd0, 32'h12345678, 1'b1, "ld2048_miss");
        req(1'b0, 32'd1024, 32'd0, 32'h11111111, 1'b0, "ld1024_lru_kept");
        req(1'b0, 32'd1536, 32'd0, 32'hA0000040, 1'b1, "ld1536_lru_evicted");

        address  = 32'd4096;
        mem_r_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid/sram_r_en_before", 32'(sram_r_en), 32'd1);
        rst      = 1'b1;
        mem_r_en = 1'b0;
        #1;
        check("rst_mid/sram_r_en", 32'(sram_r_en), 32'd0);
        check("rst_mid/ready", 32'(ready), 32'd1);
        check("rst_mid/hit_count", hit_count, 32'd0);
        check("rst_mid/miss_count", miss_count, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        lat = 1;
        req(1'b0, 32'd1024, 32'd0, 32'h11111111, 1'b1, "post_rst_ld1024_miss");
        req(1'b0, 32'd1024, 32'd0, 32'h11111111, 1'b0, "stats_hit1");
        req(1'b0, 32'd1024, 32'd0, 32'h11111111, 1'b0, "stats_hit2");
        req(1'b0, 32'd1024, 32'd0, 32'h11111111, 1'b0, "stats_hit3");
        repeat (2) @(posedge clk);
        #1;
        check("end/scoreboard_left", 32'(sb.size()), 32'd0);
        check("end/idle_rdata", rdata, 32'd0);
`ifdef CACHE_STATS_EN
        check("stats/hit_count", hit_count, 32'd3);
        check("stats/miss_count", miss_count, 32'd1);
`else
        check("stats/hit_count", hit_count, 32'd0);
        check("stats/miss_count", miss_count, 32'd0);
`endif
        finish_run();
    end
endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Two-way set-associative, read-allocate, write-through data cache between the MEM stage and the SRAM controller.
- Serves MEM-stage loads from on-chip storage when the line is present.
- On a load miss, fetches a 64-bit line through the SRAM controller.
- Forwards every store to the SRAM controller and updates the cache on a store hit.
- Drives the pipeline freeze through ready.

Parameters:
- SETS, 64, number of sets; index width = log2(SETS).
- TAG_W, 10, tag width; tag = mem_addr[18:9] at default.
- BASE_ADDR, 1024, data-memory base subtracted before indexing.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- mem_r_en  input  1  load request from MEM stage
- mem_w_en  input  1  store request from MEM stage
- address  input  32  byte address (ALU result)
- wdata  input  32  store data
- rdata  output  32  load data, valid when ready=1 and the request is a load
- ready  output  1  0 = freeze pipeline
- sram_r_en  output  1  line read request to the SRAM controller
- sram_w_en  output  1  word write request to the SRAM controller
- sram_address  output  32  address forwarded unchanged to the SRAM controller
- sram_wdata  output  32  store data forwarded
- sram_rdata  input  64  line returned by the SRAM controller
- sram_ready  input  1  SRAM controller done/idle
- hit_count  output  32  see Optional Feature
- miss_count  output  32  see Optional Feature

Behaviour:
- Address split: mem_addr = address - BASE_ADDR (32-bit, wraps).
  - word select = mem_addr[2]; index = mem_addr[8:3]; tag = mem_addr[18:9].
- Storage per set:
  - 2 ways, each with valid bit, TAG_W tag and 64-bit data (word0 = [31:0], word1 = [63:32]).
  - One LRU bit per set: 0 = way0 least recent, 1 = way1 least recent.
- Hit: (valid0 & tag0==tag) | (valid1 & tag1==tag); combinational.
- State machine, states IDLE, READ_MISS, WRITE:
  - IDLE, mem_w_en=1 -> WRITE. Write has priority if both enables are high.
  - IDLE, mem_r_en=1 & hit -> stay IDLE.
    - ready=1 the same cycle; rdata = selected word of the hitting way.
    - LRU updated at the clock edge.
  - IDLE, mem_r_en=1 & miss -> READ_MISS.
  - READ_MISS: sram_r_en=1, sram_address=address, held until sram_ready=1.
    - When sram_ready=1: ready=1; rdata = sram_rdata word selected by mem_addr[2].
    - At that edge: line, tag and valid written into the victim way, LRU updated, -> IDLE.
  - WRITE: sram_w_en=1, sram_address=address, sram_wdata=wdata, held until sram_ready=1.
    - When sram_ready=1: ready=1.
    - On a hit, the selected word of the hitting way is overwritten and LRU updated at that edge.
    - On a miss, no allocation.
    - -> IDLE.
- sram_ready is sampled only in READ_MISS/WRITE. The SRAM controller's idle-state ready pulse in the first request cycle is ignored because the FSM is still in IDLE.
- Victim selection: invalid way0 first, else invalid way1, else the way named by LRU.
- LRU update on any hit or fill: LRU <= ~accessed_way.
- ready = 1 in IDLE with no request, or on a read hit. 0 in IDLE on a miss/write request. 0 in READ_MISS/WRITE until sram_ready.
- rdata = 0 when no load completes.
- Enables drop to 0 combinationally once the FSM returns to IDLE, so the SRAM controller sees each request for exactly one transaction.
- Reset (asynchronous, any state including mid-miss):
  - state=IDLE; all valid bits=0; all LRU=0.
  - sram_r_en=sram_w_en=0; ready=1; counters=0.
  - A miss interrupted by reset leaves no partial line.
- Request deasserted mid-transaction: not legal. The pipeline is frozen, so the request is held stable.

Optional Feature:
- CACHE_STATS_EN defined:
  - hit_count increments by 1 on each completed read hit.
  - miss_count increments by 1 on each read-miss fill edge.
  - Stores are not counted. Both counters wrap at 2^32.
- Not defined: hit_count and miss_count tied to 0, counter logic absent.

Test Plan:
- After reset, load address 1024 with sram_rdata=64'h22222222_11111111 returned 5 cycles later -> ready=0 for 5 cycles; rdata=32'h11111111 on the sram_ready cycle; one sram_r_en transaction.
- Immediately load 1028 -> same-cycle ready=1, rdata=32'h22222222, sram_r_en stays 0.
- Loads 1024, then 1024+512 (same index, different tag), then 1024+1024 -> third miss evicts tag 0; a reload of 1024 misses, 1024+512 still hits.
- Store 32'hDEADBEEF to 1028 after a fill -> sram_w_en held until sram_ready; next load of 1028 hits with 32'hDEADBEEF. Store to an uncached 2048 -> a later load of 2048 misses.
- Assert rst during READ_MISS -> sram_r_en=0 and ready=1 immediately; a subsequent load of 1024 misses.
- With CACHE_STATS_EN: 1 miss + 3 hits on 1024 -> miss_count=1, hit_count=3. Without it, both read 0.
